// File: rtl/seg_scan_driver_if.sv
// Bus bundle between the result datapath (master) and seg_scan_driver (slave).
// data_in nibble 0 is the rightmost digit; seg is {a,b,c,d,e,f,g,dp}.
interface seg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] data_in;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   sel;
  logic                frame_done;

  modport master (
    output data_in, dp_in, load,
    input  seg, sel, frame_done
  );

  modport slave (
    input  data_in, dp_in, load,
    output seg, sel, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with tear-free, frame-aligned load commits.
// Optional macro SEG_LZB_EN enables leading-zero blanking (mask registered with the shadow word).
module seg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int DIV         = 50000,
  parameter int SEL_ACT_LOW = 0
) (
  input logic               clk,
  input logic               rst,
  seg_scan_driver_if.slave  bus
);

  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] SEL_IDLE = (SEL_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  function automatic logic [7:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 8'hfc;
      4'd1:    enc = 8'h60;
      4'd2:    enc = 8'hda;
      4'd3:    enc = 8'hf2;
      4'd4:    enc = 8'h66;
      4'd5:    enc = 8'hb6;
      4'd6:    enc = 8'hbe;
      4'd7:    enc = 8'he0;
      4'd8:    enc = 8'hfe;
      4'd9:    enc = 8'hf6;
      default: enc = 8'h00;
    endcase
  endfunction

`ifdef SEG_LZB_EN
  // A digit is blanked when it and every digit above it hold no nonzero BCD value.
  function automatic logic [DIGITS-1:0] lzb_mask(input logic [DIGITS-1:0][3:0] w);
    logic seen;
    seen     = 1'b0;
    lzb_mask = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen        = seen | ((w[i] >= 4'd1) && (w[i] <= 4'd9));
      lzb_mask[i] = ~seen;
    end
  endfunction
`endif

  logic [PW-1:0]              presc_r;
  logic [IDXW-1:0]            idx_r;
  logic [DIGITS-1:0][3:0]     shadow_r;
  logic [DIGITS-1:0]          shadow_dp_r;
  logic [DIGITS-1:0][3:0]     stage_r;
  logic [DIGITS-1:0]          stage_dp_r;
  logic                       pending_r;
  logic [7:0]                 seg_r;
  logic [DIGITS-1:0]          sel_r;
  logic                       frame_done_r;
`ifdef SEG_LZB_EN
  logic [DIGITS-1:0]          blank_r;
`endif

  logic                       tick_s;
  logic                       boundary_s;
  logic                       commit_s;
  logic [DIGITS-1:0][3:0]     commit_data_s;
  logic [DIGITS-1:0]          commit_dp_s;
  logic [3:0]                 cur_digit_s;
  logic                       cur_dp_s;
  logic [7:0]                 seg_s;
  logic [DIGITS-1:0]          sel_s;

  assign tick_s        = (presc_r == PW'(DIV - 1));
  assign boundary_s    = tick_s && (idx_r == IDXW'(DIGITS - 1));
  assign commit_s      = boundary_s && (bus.load || pending_r);
  // A load on the boundary cycle bypasses the stage so it lands this frame.
  assign commit_data_s = bus.load ? bus.data_in : stage_r;
  assign commit_dp_s   = bus.load ? bus.dp_in   : stage_dp_r;

  // Next segment code and digit select for the digit under the scan index
  always_comb begin
    cur_digit_s = shadow_r[idx_r];
    cur_dp_s    = shadow_dp_r[idx_r];
`ifdef SEG_LZB_EN
    if (blank_r[idx_r]) begin
      seg_s = {7'b0000000, cur_dp_s};
    end else begin
      seg_s = enc(cur_digit_s) | {7'b0000000, cur_dp_s};
    end
`else
    seg_s = enc(cur_digit_s) | {7'b0000000, cur_dp_s};
`endif
    sel_s = {DIGITS{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      sel_s[i] = (idx_r == IDXW'(i));
    end
  end

  // Scan timing, load staging, frame commit and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r      <= {PW{1'b0}};
      idx_r        <= {IDXW{1'b0}};
      shadow_r     <= {DIGITS{4'hF}};
      shadow_dp_r  <= {DIGITS{1'b0}};
      stage_r      <= {DIGITS{4'h0}};
      stage_dp_r   <= {DIGITS{1'b0}};
      pending_r    <= 1'b0;
      seg_r        <= 8'h00;
      sel_r        <= SEL_IDLE;
      frame_done_r <= 1'b0;
`ifdef SEG_LZB_EN
      blank_r      <= {DIGITS{1'b0}};
`endif
    end else begin
      presc_r <= tick_s ? {PW{1'b0}} : (presc_r + PW'(1'b1));
      if (tick_s) begin
        idx_r <= (idx_r == IDXW'(DIGITS - 1)) ? {IDXW{1'b0}} : (idx_r + IDXW'(1'b1));
      end
      if (bus.load) begin
        stage_r    <= bus.data_in;
        stage_dp_r <= bus.dp_in;
      end
      if (boundary_s) begin
        pending_r <= 1'b0;
      end else if (bus.load) begin
        pending_r <= 1'b1;
      end
      if (commit_s) begin
        shadow_r    <= commit_data_s;
        shadow_dp_r <= commit_dp_s;
`ifdef SEG_LZB_EN
        blank_r     <= lzb_mask(commit_data_s);
`endif
      end
      frame_done_r <= boundary_s;
      seg_r        <= seg_s;
      sel_r        <= (SEL_ACT_LOW != 0) ? ~sel_s : sel_s;
    end
  end

  assign bus.seg        = seg_r;
  assign bus.sel        = sel_r;
  assign bus.frame_done = frame_done_r;

endmodule
